// File: rtl/fp_dot_accumulator.sv
// Streaming FP32 dot-product engine: acc = init + sum(B[i]*C[i]), one fused multiply-add per beat.
// Command/operand/result valid-ready handshakes, one operand register stage, abort and NaN/Inf status.
module fp_dot_accumulator #(
  parameter int PARM_XLEN  = 32,
  parameter int PARM_EXP   = 8,
  parameter int PARM_MANT  = 23,
  parameter int PARM_BIAS  = 127,
  parameter int PARM_LEN_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [PARM_LEN_W-1:0] cmd_len,
  input  logic [PARM_XLEN-1:0]  cmd_init,
  input  logic                  abort_i,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PARM_XLEN-1:0]  in_b,
  input  logic [PARM_XLEN-1:0]  in_c,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [PARM_XLEN-1:0]  res_data,
  output logic                  res_nan,
  output logic                  res_inf
);
  localparam int SIG = PARM_MANT + 1;
  localparam int PW  = 2 * SIG;
  localparam int SW  = PW + 4;
  localparam int EW  = PARM_EXP + 5;
  localparam logic signed [EW-1:0] EXP_ZERO = EW'(-(2 ** (PARM_EXP + 3)));
  localparam logic signed [EW-1:0] EXP_ONE  = EW'(1);
  localparam logic signed [EW-1:0] EXP_MAX  = EW'((2 ** PARM_EXP) - 1);
  localparam logic [PARM_XLEN-1:0] QNAN = {1'b0, {PARM_EXP{1'b1}}, 1'b1, {(PARM_MANT-1){1'b0}}};
  localparam logic [PARM_XLEN-2:0] INF_MAG = {{PARM_EXP{1'b1}}, {PARM_MANT{1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUT} state_t;

  state_t                state_q, state_d;
  logic [PARM_XLEN-1:0]  acc_q, acc_d, op_b_q, op_b_d, op_c_q, op_c_d;
  logic [PARM_LEN_W-1:0] remaining_q, remaining_d;
  logic                  op_valid_q, op_valid_d;
  logic [PARM_XLEN-1:0]  fma_res;

  function automatic logic [7:0] msb_pos(input logic [SW-1:0] v);
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < SW; i++) begin
      if (v[i]) p = 8'(i);
    end
    return p;
  endfunction

  // Right shift that folds every shifted-out one into bit 0 (sticky).
  function automatic logic [SW-1:0] shr_sticky(input logic [SW-1:0] v, input logic [EW-1:0] amt);
    logic [SW-1:0] r;
    logic          lost;
    r    = v >> amt;
    lost = (r << amt) != v;
    r[0] = r[0] | lost;
    return r;
  endfunction

  logic                  sa, sb, sc, sp, big_s, eff_sub, a_big, round_up;
  logic                  a_nan, b_nan, c_nan, a_inf, b_inf, c_inf, b_zero, c_zero, p_inf;
  logic [PARM_EXP-1:0]   ea_f, eb_f, ec_f, exp_field;
  logic [SIG-1:0]        ma, mb, mc;
  logic [PW-1:0]         sig_a, sig_p, big_sig, sm_sig;
  logic signed [EW-1:0]  e_a, e_p, big_e, sm_e, re;
  logic [EW-1:0]         d;
  logic [SW-1:0]         x, y, s, n;
  logic [7:0]            pos_a, pos_p, pos_s;
  logic [PARM_XLEN-2:0]  mag;

  // Single-rounding A + B*C with A = acc: both addends are normalised to a PW-bit significand whose
  // MSB weighs 2^(e-bias), aligned with guard/round/sticky bits, summed exactly, then rounded once.
  always_comb begin
    sa   = acc_q[PARM_XLEN-1];
    sb   = op_b_q[PARM_XLEN-1];
    sc   = op_c_q[PARM_XLEN-1];
    ea_f = acc_q[PARM_XLEN-2 -: PARM_EXP];
    eb_f = op_b_q[PARM_XLEN-2 -: PARM_EXP];
    ec_f = op_c_q[PARM_XLEN-2 -: PARM_EXP];
    ma   = {ea_f != '0, acc_q[PARM_MANT-1:0]};
    mb   = {eb_f != '0, op_b_q[PARM_MANT-1:0]};
    mc   = {ec_f != '0, op_c_q[PARM_MANT-1:0]};
    a_nan  = (&ea_f) && (acc_q[PARM_MANT-1:0] != '0);
    b_nan  = (&eb_f) && (op_b_q[PARM_MANT-1:0] != '0);
    c_nan  = (&ec_f) && (op_c_q[PARM_MANT-1:0] != '0);
    a_inf  = (&ea_f) && (acc_q[PARM_MANT-1:0] == '0);
    b_inf  = (&eb_f) && (op_b_q[PARM_MANT-1:0] == '0);
    c_inf  = (&ec_f) && (op_c_q[PARM_MANT-1:0] == '0);
    b_zero = (eb_f == '0) && (op_b_q[PARM_MANT-1:0] == '0);
    c_zero = (ec_f == '0) && (op_c_q[PARM_MANT-1:0] == '0);
    sp     = sb ^ sc;
    p_inf  = b_inf | c_inf;

    sig_a = {ma, {SIG{1'b0}}};
    e_a   = EW'(ea_f) + EW'(ea_f == '0);
    pos_a = msb_pos({{(SW-PW){1'b0}}, sig_a});
    if (sig_a == '0) begin
      e_a = EXP_ZERO;
    end else begin
      sig_a = sig_a << (PW - 1 - pos_a);
      e_a   = e_a - EW'(PW - 1 - pos_a);
    end

    sig_p = mb * mc;
    e_p   = EW'(eb_f) + EW'(eb_f == '0) + EW'(ec_f) + EW'(ec_f == '0) - EW'(PARM_BIAS - 1);
    pos_p = msb_pos({{(SW-PW){1'b0}}, sig_p});
    if (sig_p == '0) begin
      e_p = EXP_ZERO;
    end else begin
      sig_p = sig_p << (PW - 1 - pos_p);
      e_p   = e_p - EW'(PW - 1 - pos_p);
    end

    a_big   = (e_a > e_p) || ((e_a == e_p) && (sig_a >= sig_p));
    big_sig = a_big ? sig_a : sig_p;
    sm_sig  = a_big ? sig_p : sig_a;
    big_e   = a_big ? e_a : e_p;
    sm_e    = a_big ? e_p : e_a;
    big_s   = a_big ? sa : sp;
    d       = big_e - sm_e;
    x       = {1'b0, big_sig, 3'b000};
    y       = shr_sticky({1'b0, sm_sig, 3'b000}, d);
    eff_sub = sa ^ sp;
    s       = eff_sub ? (x - y) : (x + y);

    pos_s = msb_pos(s);
    n     = s << (SW - 1 - pos_s);
    re    = big_e + EW'(pos_s) - EW'(SW - 2);
    if (re < EXP_ONE) n = shr_sticky(n, EXP_ONE - re);
    // After a subnormal shift the hidden bit is gone, so the exponent field encodes as zero.
    exp_field = n[SW-1] ? re[PARM_EXP-1:0] : '0;
    round_up  = n[SW-SIG-1] & ((|n[SW-SIG-2:0]) | n[SW-SIG]);
    mag       = {exp_field, n[SW-2 -: PARM_MANT]} + (PARM_XLEN-1)'(round_up);

    if (a_nan | b_nan | c_nan | (b_inf & c_zero) | (b_zero & c_inf) | (a_inf & p_inf & (sa != sp)))
      fma_res = QNAN;
    else if (a_inf)
      fma_res = {sa, INF_MAG};
    else if (p_inf)
      fma_res = {sp, INF_MAG};
    else if (s == '0)
      fma_res = {sa & sp, {(PARM_XLEN-1){1'b0}}};
    else if (re >= EXP_MAX)
      fma_res = {big_s, INF_MAG};
    else
      fma_res = {big_s, mag};
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    remaining_d = remaining_q;
    op_valid_d  = 1'b0;
    op_b_d      = op_b_q;
    op_c_d      = op_c_q;
    if (op_valid_q) acc_d = fma_res;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          acc_d       = cmd_init;
          remaining_d = cmd_len;
          state_d     = (cmd_len == '0) ? OUT : ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid && (remaining_q != '0)) begin
          op_b_d      = in_b;
          op_c_d      = in_c;
          op_valid_d  = 1'b1;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == PARM_LEN_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN:   state_d = OUT;
      OUT:     if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_i && (state_q != IDLE)) begin
      state_d     = IDLE;
      op_valid_d  = 1'b0;
      acc_d       = '0;
      remaining_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      remaining_q <= '0;
      op_valid_q  <= 1'b0;
      op_b_q      <= '0;
      op_c_q      <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      remaining_q <= remaining_d;
      op_valid_q  <= op_valid_d;
      op_b_q      <= op_b_d;
      op_c_q      <= op_c_d;
    end
  end

  assign cmd_ready = (state_q == IDLE) & ~rst;
  assign in_ready  = (state_q == ACCUM) & (remaining_q != '0);
  assign res_valid = (state_q == OUT);
  assign res_data  = res_valid ? acc_q : '0;
  assign res_nan   = (&res_data[PARM_XLEN-2 -: PARM_EXP]) & (res_data[PARM_MANT-1:0] != '0);
  assign res_inf   = (&res_data[PARM_XLEN-2 -: PARM_EXP]) & (res_data[PARM_MANT-1:0] == '0);
endmodule
